// File: rtl/hazard_ctrl_if.sv
// Hazard controller signal bundle: pipeline-side hazard sources in, stall/flush controls out.
// master = pipeline datapath, slave = hazard_ctrl.
interface hazard_ctrl_if;
    logic [4:0]  Rs_id;
    logic [4:0]  Rt_id;
    logic        use_rt_id;
    logic [4:0]  Rt_ex;
    logic        MemtoReg_ex;
    logic        RegWr_ex;
    logic        br_taken;
    logic        pc_stall;
    logic        ifid_stall;
    logic        ifid_flush;
    logic        if_ctrl;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    modport master (
        output Rs_id, Rt_id, use_rt_id, Rt_ex, MemtoReg_ex, RegWr_ex, br_taken,
        input  pc_stall, ifid_stall, ifid_flush, if_ctrl, stall_cnt, flush_cnt
    );

    modport slave (
        input  Rs_id, Rt_id, use_rt_id, Rt_ex, MemtoReg_ex, RegWr_ex, br_taken,
        output pc_stall, ifid_stall, ifid_flush, if_ctrl, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles and taken-branch squash, Mealy outputs.
// Optional performance counters enabled by defining HAZ_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int unsigned LOAD_BUBBLES = 1,
    parameter int unsigned BR_FLUSH_CYC = 2
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        BFLUSH = 2'd2
    } state_t;

    localparam logic [2:0] LB_INIT = 3'(LOAD_BUBBLES - 1);
    localparam logic [2:0] BF_INIT = 3'(BR_FLUSH_CYC - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       lu_hit;
    logic       stall, flush;

    assign lu_hit = hz.MemtoReg_ex & hz.RegWr_ex & (hz.Rt_ex != 5'd0) &
                    ((hz.Rt_ex == hz.Rs_id) | (hz.use_rt_id & (hz.Rt_ex == hz.Rt_id)));

    // State advances on the falling edge, in step with the pipeline registers.
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        flush   = 1'b0;

        // A taken branch overrides any pending stall and (re)starts the flush window.
        if (hz.br_taken) begin
            flush = 1'b1;
            if (BR_FLUSH_CYC > 1) begin
                state_d = BFLUSH;
                cnt_d   = BF_INIT;
            end else begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (lu_hit) begin
                        stall = 1'b1;
                        if (LOAD_BUBBLES > 1) begin
                            state_d = LSTALL;
                            cnt_d   = LB_INIT;
                        end
                    end
                end
                LSTALL: begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) state_d = RUN;
                end
                BFLUSH: begin
                    flush = 1'b1;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end

        if (rst) begin
            stall = 1'b0;
            flush = 1'b0;
        end
    end

    assign hz.pc_stall   = stall;
    assign hz.ifid_stall = stall;
    assign hz.ifid_flush = flush;
    assign hz.if_ctrl    = stall | flush;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(negedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`else
    assign hz.stall_cnt = '0;
    assign hz.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (LOAD_BUBBLES=2, BR_FLUSH_CYC=2); counter checks follow HAZ_PERF_CNT_EN.
// Inputs change just after the falling edge; outputs are checked just after the rising edge.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if hz();

    hazard_ctrl #(
        .LOAD_BUBBLES(2),
        .BR_FLUSH_CYC(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    // exp = {pc_stall, ifid_stall, ifid_flush, if_ctrl}
    task automatic cyc(input string tag, input logic r, input logic br,
                       input logic mem, input logic rw, input logic [4:0] rt_ex,
                       input logic [4:0] rs_id, input logic [4:0] rt_id,
                       input logic use_rt, input logic [3:0] exp);
        logic [3:0] obs;
        @(negedge clk);
        #1;
        rst            = r;
        hz.br_taken    = br;
        hz.MemtoReg_ex = mem;
        hz.RegWr_ex    = rw;
        hz.Rt_ex       = rt_ex;
        hz.Rs_id       = rs_id;
        hz.Rt_id       = rt_id;
        hz.use_rt_id   = use_rt;
        @(posedge clk);
        #1;
        obs = {hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.if_ctrl};
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        hz.br_taken    = 1'b1;
        hz.MemtoReg_ex = 1'b1;
        hz.RegWr_ex    = 1'b1;
        hz.Rt_ex       = 5'd5;
        hz.Rs_id       = 5'd5;
        hz.Rt_id       = 5'd5;
        hz.use_rt_id   = 1'b1;

        // Reset held with every hazard source active
        cyc("rst0",      1, 1, 1, 1, 5'd5, 5'd5, 5'd5, 1, 4'b0000);
        cyc("rst1",      1, 1, 1, 1, 5'd5, 5'd5, 5'd5, 1, 4'b0000);
        cyc("idle",      0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 4'b0000);

        // Load-use on rs: exactly two bubbles
        cyc("lu_rs_c1",  0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0, 4'b1101);
        cyc("lu_rs_c2",  0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 4'b1101);
        cyc("lu_rs_end", 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 4'b0000);

        // r0 and operand-use qualifiers
        cyc("rt_ex_r0",  0, 0, 1, 1, 5'd0, 5'd0, 5'd0, 0, 4'b0000);
        cyc("rt_unused", 0, 0, 1, 1, 5'd5, 5'd3, 5'd5, 0, 4'b0000);
        cyc("lu_rt_c1",  0, 0, 1, 1, 5'd5, 5'd3, 5'd5, 1, 4'b1101);
        cyc("lu_rt_c2",  0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 4'b1101);
        cyc("lu_rt_end", 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 4'b0000);
        cyc("no_regwr",  0, 0, 1, 0, 5'd5, 5'd5, 5'd0, 0, 4'b0000);
        cyc("no_load",   0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 4'b0000);

        // Taken branch: two flush cycles, no stall
        cyc("br_c1",     0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 4'b0011);
        cyc("br_c2",     0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 4'b0011);
        cyc("br_end",    0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 4'b0000);

        // Branch and load-use in the same cycle: branch wins
        cyc("brlu_c1",   0, 1, 1, 1, 5'd7, 5'd7, 5'd0, 0, 4'b0011);
        cyc("brlu_c2",   0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 4'b0011);
        cyc("brlu_end",  0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 4'b0000);

        // Branch during the second stall cycle aborts the stall
        cyc("col_lu",    0, 0, 1, 1, 5'd9, 5'd9, 5'd0, 0, 4'b1101);
        cyc("col_br",    0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 4'b0011);
        cyc("col_fl2",   0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 4'b0011);
        cyc("col_end",   0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 4'b0000);

        // Back-to-back branches extend the flush window to three cycles
        cyc("b2b_t0",    0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 4'b0011);
        cyc("b2b_t1",    0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 4'b0011);
        cyc("b2b_t2",    0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 4'b0011);
        cyc("b2b_end",   0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 4'b0000);

        // Reset in the middle of a stall returns to RUN
        cyc("mid_lu",    0, 0, 1, 1, 5'd4, 5'd4, 5'd0, 0, 4'b1101);
        cyc("mid_rst",   1, 0, 1, 1, 5'd4, 5'd4, 5'd0, 0, 4'b0000);
        cyc("mid_after", 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 4'b0000);

        // Counters: two stall cycles plus two flush cycles since a fresh reset
        cyc("cnt_rst",   1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 4'b0000);
        cyc("cnt_lu1",   0, 0, 1, 1, 5'd6, 5'd6, 5'd0, 0, 4'b1101);
        cyc("cnt_lu2",   0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 4'b1101);
        cyc("cnt_br1",   0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 4'b0011);
        cyc("cnt_br2",   0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 4'b0011);
        cyc("cnt_idle",  0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 4'b0000);
`ifdef HAZ_PERF_CNT_EN
        check32("stall_cnt", hz.stall_cnt, 32'd2);
        check32("flush_cnt", hz.flush_cnt, 32'd2);

        // Preload all-ones, then one stall cycle wraps the stall counter
        @(negedge clk);
        #1;
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        force dut.flush_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        release dut.flush_cnt_q;
        cyc("wrap_lu",   0, 0, 1, 1, 5'd6, 5'd6, 5'd0, 0, 4'b1101);
        @(negedge clk);
        #2;
        check32("stall_wrap", hz.stall_cnt, 32'd0);
        check32("flush_hold", hz.flush_cnt, 32'hFFFF_FFFF);
`else
        check32("stall_cnt", hz.stall_cnt, 32'd0);
        check32("flush_cnt", hz.flush_cnt, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
